// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the cache/memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int LINE_OFF_W = 4;
  localparam int WORD_CNT_W = 4;

  // Observation bundle: FSM state, current owner and both line counters.
  typedef struct packed {
    state_t                state;
    owner_t                owner;
    logic [WORD_CNT_W-1:0] icnt;
    logic [WORD_CNT_W-1:0] rcnt;
    logic                  issue_last;
  } dbg_t;

endpackage

// File: rtl/fill_counter.sv
// Word counter for one line transfer: clear, enable and a last-word flag.
module fill_counter
  import mem_arb_pkg::*;
#(
  parameter int LAST_VAL = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_CNT_W-1:0] cnt,
  output logic                  last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WORD_CNT_W'(1);
    end
  end

  assign last = (cnt == WORD_CNT_W'(LAST_VAL));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache access to a pipelined main memory:
// 8-word line fills issued back-to-back and single-word write-through stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int MEM_LAT        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] i_word_addr,
  output logic              i_data_valid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_data,
  output logic [ADDR_W-1:0] d_word_addr,
  output logic              d_data_valid,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output dbg_t              dbg
);

  // Handshake: *_req is a level held until the matching *_done pulse; the
  // requester drops it on the following edge. mem_en/mem_wr are a one-cycle
  // command with no back-pressure; mem_rdata_valid returns MEM_LAT cycles later.

  if (MEM_LAT < 1 || WORDS_PER_LINE != 8 || ADDR_W <= LINE_OFF_W) begin : g_bad_cfg
    $error("mem_arbiter: unsupported parameter combination");
  end

  localparam logic [ADDR_W-1:0]     LINE_MASK = ~ADDR_W'((1 << LINE_OFF_W) - 1);
  localparam logic [WORD_CNT_W-1:0] CNT_END   = WORD_CNT_W'(WORDS_PER_LINE);

  state_t                state;
  owner_t                owner;
  logic [ADDR_W-1:0]     base;
  logic [WORD_CNT_W-1:0] icnt, rcnt;
  logic                  icnt_last, rcnt_last;
  logic                  fill_start, issue_active, ret_fire, ret_done;
  logic [ADDR_W-1:0]     ret_addr;

  assign fill_start   = (state == IDLE) && ((d_req && !d_we) || (!d_req && i_req));
  assign issue_active = (state == FILL) && (icnt != CNT_END);
  // Returns beyond the eighth word are dropped so a stray strobe cannot overrun the line.
  assign ret_fire     = (state == FILL) && mem_rdata_valid && (rcnt != CNT_END);
  assign ret_done     = ret_fire && rcnt_last;
  assign ret_addr     = base | {{(ADDR_W-WORD_CNT_W-1){1'b0}}, rcnt, 1'b0};

  fill_counter #(.LAST_VAL(WORDS_PER_LINE-1)) u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (fill_start),
    .en   (issue_active),
    .cnt  (icnt),
    .last (icnt_last)
  );

  fill_counter #(.LAST_VAL(WORDS_PER_LINE-1)) u_ret_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (fill_start),
    .en   (ret_fire),
    .cnt  (rcnt),
    .last (rcnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_I;
      base  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            owner <= OWN_D;
            base  <= d_addr & LINE_MASK;
            state <= d_we ? WRITE : FILL;
          end else if (i_req) begin
            owner <= OWN_I;
            base  <= i_addr & LINE_MASK;
            state <= FILL;
          end
        end
        FILL:    if (ret_done) state <= IDLE;
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = issue_active || (state == WRITE);
    mem_wr    = (state == WRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WRITE) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (issue_active) begin
      mem_addr = base | {{(ADDR_W-WORD_CNT_W-1){1'b0}}, icnt, 1'b0};
    end
  end

  always_comb begin
    i_data       = '0;
    i_word_addr  = '0;
    i_data_valid = 1'b0;
    i_done       = 1'b0;
    d_data       = '0;
    d_word_addr  = '0;
    d_data_valid = 1'b0;
    d_done       = (state == WRITE);
    if (ret_fire) begin
      if (owner == OWN_I) begin
        i_data       = mem_rdata;
        i_word_addr  = ret_addr;
        i_data_valid = 1'b1;
        i_done       = rcnt_last;
      end else begin
        d_data       = mem_rdata;
        d_word_addr  = ret_addr;
        d_data_valid = 1'b1;
        d_done       = rcnt_last;
      end
    end
  end

  assign dbg = '{state: state, owner: owner, icnt: icnt, rcnt: rcnt, issue_last: icnt_last};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random I/D traffic, each cycle
// compared against a transaction-timeline reference model and a 4-cycle memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;
  localparam logic [DW-1:0] SALT = 16'h5A3C;

  logic          clk, rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, i_word_addr, d_word_addr, mem_addr;
  logic [DW-1:0] d_wdata, i_data, d_data, mem_wdata, mem_rdata;
  logic          i_data_valid, i_done, d_data_valid, d_done;
  logic          mem_en, mem_wr, mem_rdata_valid;
  dbg_t          dbg;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(8), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_word_addr(i_word_addr),
    .i_data_valid(i_data_valid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_data(d_data), .d_word_addr(d_word_addr), .d_data_valid(d_data_valid), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .dbg(dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory: fixed-latency read pipe ----------------
  function automatic logic [DW-1:0] init_val(input logic [AW-2:0] a);
    return DW'({1'b0, a} * 16'h9E37) ^ SALT;
  endfunction

  bit   [DW-1:0] mem_arr [32768];
  bit            mem_flag [32768];
  logic [LAT-1:0] pipe_v;
  logic [AW-1:0]  pipe_a [LAT];
  logic           spurious;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v    <= {pipe_v[LAT-2:0], mem_en & ~mem_wr};
      pipe_a[0] <= mem_addr;
      for (int k = 1; k < LAT; k++) pipe_a[k] <= pipe_a[k-1];
      if (mem_en && mem_wr) begin
        mem_arr[mem_addr[AW-1:1]]  <= mem_wdata;
        mem_flag[mem_addr[AW-1:1]] <= 1'b1;
      end
    end
  end

  assign mem_rdata_valid = pipe_v[LAT-1] | spurious;
  assign mem_rdata = !pipe_v[LAT-1] ? '0 :
                     mem_flag[pipe_a[LAT-1][AW-1:1]] ? mem_arr[pipe_a[LAT-1][AW-1:1]] :
                     init_val(pipe_a[LAT-1][AW-1:1]);

  // ---------------- scoreboard / checker ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model: one transaction on a cycle timeline ----------------
  int            cyc;
  int            t_start;
  bit            act, m_fill;
  owner_t        m_own;
  logic [AW-1:0] m_base, m_waddr;
  logic [DW-1:0] m_wdata;
  bit   [DW-1:0] m_mem [32768];
  bit            m_flag [32768];
  bit            i_dropped, d_dropped;

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    return m_flag[a[AW-1:1]] ? m_mem[a[AW-1:1]] : init_val(a[AW-1:1]);
  endfunction

  // Decide the grant for the current cycle from the request levels now on the pins.
  task automatic arbitrate();
    int k;
    bit busy;
    k    = cyc - t_start;
    busy = act && (m_fill ? (k <= 8 + LAT) : (k <= 1));
    if (!busy) begin
      act = 1'b0;
      if (d_req) begin
        act = 1'b1; t_start = cyc; m_own = OWN_D; m_fill = !d_we;
        m_base = d_addr & 16'hFFF0; m_waddr = d_addr; m_wdata = d_wdata;
        if (d_we) begin
          m_mem[d_addr[AW-1:1]]  = d_wdata;
          m_flag[d_addr[AW-1:1]] = 1'b1;
        end
      end else if (i_req) begin
        act = 1'b1; t_start = cyc; m_own = OWN_I; m_fill = 1'b1;
        m_base = i_addr & 16'hFFF0;
      end
    end
  endtask

  task automatic check_cycle();
    int k, j;
    bit e_iss, e_wr, e_ret, e_done, e_fill;
    state_t e_st;
    logic [AW-1:0] wa;
    k      = cyc - t_start;
    e_fill = act && m_fill && k >= 1 && k <= 8 + LAT;
    e_iss  = act && m_fill && k >= 1 && k <= 8;
    e_wr   = act && !m_fill && k == 1;
    e_ret  = act && m_fill && k >= 1 + LAT && k <= 8 + LAT;
    e_done = e_ret && k == 8 + LAT;
    e_st   = e_fill ? FILL : (e_wr ? WRITE : IDLE);
    check("state", 32'(dbg.state), 32'(e_st));
    check("mem_en", 32'(mem_en), 32'(e_iss || e_wr));
    if (e_iss || e_wr) check("mem_wr", 32'(mem_wr), 32'(e_wr));
    if (e_iss) check("rd_addr", 32'(mem_addr), 32'(m_base + AW'(2 * (k - 1))));
    if (e_wr) begin
      check("wr_addr", 32'(mem_addr), 32'(m_waddr));
      check("wr_data", 32'(mem_wdata), 32'(m_wdata));
    end
    check("i_valid", 32'(i_data_valid), 32'(e_ret && m_own == OWN_I));
    check("i_done", 32'(i_done), 32'(e_done && m_own == OWN_I));
    check("d_valid", 32'(d_data_valid), 32'(e_ret && m_own == OWN_D));
    check("d_done", 32'(d_done), 32'((e_done && m_own == OWN_D) || e_wr));
    if (e_ret) begin
      j  = k - 1 - LAT;
      wa = m_base + AW'(2 * j);
      if (m_own == OWN_I) begin
        check("i_word_addr", 32'(i_word_addr), 32'(wa));
        check("i_data", 32'(i_data), 32'(exp_word(wa)));
      end else begin
        check("d_word_addr", 32'(d_word_addr), 32'(wa));
        check("d_data", 32'(d_data), 32'(exp_word(wa)));
      end
    end
    // Requesters drop their level on the edge after done.
    i_dropped = 1'b0;
    d_dropped = 1'b0;
    if (e_done && m_own == OWN_I) begin
      i_req = 1'b0; i_dropped = 1'b1;
    end
    if ((e_done && m_own == OWN_D) || e_wr) begin
      d_req = 1'b0; d_we = 1'b0; d_dropped = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    for (int s = 0; s < n; s++) begin
      arbitrate();
      @(negedge clk);
      cyc++;
      check_cycle();
      spurious = 1'b0;
    end
  endtask

  task automatic raise_i(input logic [AW-1:0] a);
    i_req  = 1'b1;
    i_addr = a;
  endtask

  task automatic raise_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = w;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(dbg.state), 32'(IDLE));
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_i_out"}, {i_data, i_word_addr}, 32'd0);
    check({tag, "_i_flags"}, 32'({i_data_valid, i_done}), 32'd0);
    check({tag, "_d_out"}, {d_data, d_word_addr}, 32'd0);
    check({tag, "_d_flags"}, 32'({d_data_valid, d_done}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; spurious = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    cyc = 0; t_start = -100; act = 1'b0; m_fill = 1'b0; m_own = OWN_I;
    m_base = '0; m_waddr = '0; m_wdata = '0; i_dropped = 1'b0; d_dropped = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_icnt", 32'(dbg.icnt), 32'd0);
    check("reset_rcnt", 32'(dbg.rcnt), 32'd0);
    rst = 1'b0;

    raise_i(16'h1236);                         run(16);
    raise_d(1'b1, 16'h0040, 16'hBEEF);         run(4);
    raise_i(16'h4ABC); raise_d(1'b0, 16'h2000, '0); run(30);
    raise_i(16'h5678); run(3);
    raise_d(1'b0, 16'h3008, '0);               run(30);

    // Reset after the fifth fill word has been delivered.
    raise_i(16'h7770); run(9);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    i_req = 1'b0; act = 1'b0;
    @(negedge clk);
    cyc++;
    check_all_zero("rst_hold");
    rst = 1'b0;
    raise_i(16'h0010); run(16);

    // Stray read-valid while idle must be ignored.
    spurious = 1'b1; run(1);
    check("spur_icnt", 32'(dbg.icnt), 32'd8);
    check("spur_rcnt", 32'(dbg.rcnt), 32'd8);
    raise_i(16'h0100); run(16);

    for (int n = 0; n < 400; n++) begin
      if (!i_req && !i_dropped && $urandom_range(0, 3) == 0) raise_i(16'($urandom));
      if (!d_req && !d_dropped && $urandom_range(0, 4) == 0)
        raise_d(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      run(1);
    end
    run(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sits between the instruction cache, the data cache and the shared 4-cycle pipelined main memory. Grants one requester at a time. Serves 8-word line fills as back-to-back pipelined reads and single-word write-through stores. Returns fill words to the granted cache in arrival order, with word address and a final-word done pulse.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS_PER_LINE, 8, words per cache line (16-byte line)
- MEM_LAT, 4, cycles from read issue to `mem_rdata_valid`

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  I-cache fill request; level, held until `i_done`
- i_addr  in  ADDR_W  miss address; low 4 bits ignored
- i_data  out  DATA_W  fill word
- i_word_addr  out  ADDR_W  byte address of `i_data`
- i_data_valid  out  1  `i_data` is valid this cycle
- i_done  out  1  one-cycle pulse with final fill word
- d_req  in  1  D-cache request; level, held until `d_done`
- d_we  in  1  1 = single-word write, 0 = line fill; stable while `d_req` is high
- d_addr  in  ADDR_W  miss or write address
- d_wdata  in  DATA_W  write data
- d_data, d_word_addr, d_data_valid, d_done  out  DATA_W/ADDR_W/1/1  same meaning as the I-side signals
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  write when `mem_en` is high
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data
- mem_rdata_valid  in  1  `mem_rdata` is valid

## Operation
- States: IDLE, FILL, WRITE. Registers: `owner` (I/D), `base` (`addr & 16'hFFF0`), issue counter `icnt` (0..8), return counter `rcnt` (0..8).
- IDLE:
  - If `d_req` is high, grant D. Go to WRITE if `d_we`, else FILL.
  - Else if `i_req` is high, grant I and go to FILL.
  - D has fixed priority over I.
  - On entry to FILL, latch `base` and clear both counters.
- FILL, read issue:
  - While `icnt < 8`, drive `mem_en=1`, `mem_wr=0`, `mem_addr = base | (icnt<<1)`, then increment `icnt`.
  - Issue is one read per cycle with no bubbles.
- FILL, data return:
  - Each `mem_rdata_valid` is forwarded to the owner: `*_data = mem_rdata`, `*_word_addr = base | (rcnt<<1)`, `*_data_valid = 1`. Then increment `rcnt`.
  - `*_done` is asserted together with the valid for `rcnt==7`. Next state is IDLE.
- WRITE: a single cycle.
  - Drive `mem_en=1`, `mem_wr=1`, `mem_addr=d_addr`, `mem_wdata=d_wdata`, `d_done=1`.
  - Next state is IDLE.
- Requesters drop `*_req` on the edge after `*_done`. IDLE therefore never re-grants a completed request.
- The non-owner's valid/done are always 0. Its data/word_addr values are don't-care.
- `mem_rdata_valid` outside FILL, or after `rcnt` reaches 8, is ignored.
- An I request arriving during a D transaction waits in IDLE arbitration. It is never dropped.
- A `d_req` that rises during an I fill is served only after `i_done`. There is no preemption.

## Timing
- Reset values: state=IDLE, `owner`=I, counters=0, `base`=0. All outputs are 0, including `mem_addr` and `mem_wdata`.
- Reset mid-operation: return to IDLE immediately, with no done pulse. Memory shares `rst`, so no stale returns follow.
- Fill accepted in IDLE at cycle t:
  - Reads issue at t+1..t+8.
  - First valid at t+1+MEM_LAT.
  - Done at t+8+MEM_LAT. With MEM_LAT=4 this is t+12.
  - Next grant is possible at t+13.
- Write accepted in IDLE at cycle t: memory write and `d_done` both occur at t+1; IDLE again at t+2.
- Outputs to the caches are combinational from state, `owner` and `mem_rdata*`. Memory outputs are combinational from state and counters.
- Address arithmetic wraps within the line only: `base | offset`, with no carry into bit 4.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` {IDLE, FILL, WRITE}
  - `owner_t` {OWN_I, OWN_D}
  - `LINE_OFF_W=4`, `WORD_CNT_W=4`
- Sub-module `fill_counter`: 4-bit counter with clear, enable, async reset and a `last` (==7) flag. Instantiated twice, for issue and return.

## Test plan
- I fill of `i_addr=16'h1236`:
  - Issues reads at 1230, 1232, …, 123E on consecutive cycles.
  - `i_data_valid` ×8 with `i_word_addr` 1230..123E.
  - `i_done` at request+12.
- `d_req=1`, `d_we=1`, `d_addr=16'h0040`, `d_wdata=16'hBEEF`:
  - One cycle with `mem_en=1`, `mem_wr=1`, `mem_addr=0040`, `mem_wdata=BEEF`, and `d_done` in that same cycle.
- `i_req` and D fill of `16'h2000` asserted together:
  - D fill completes first.
  - I fill starts the cycle after D returns to IDLE.
  - No I-side valids occur during the D fill.
- `d_req` raised at cycle 3 of an I fill: I fill completes undisturbed, then the D request is granted.
- `rst` pulsed after 5 fill words:
  - All outputs are 0 immediately.
  - No `i_done` is asserted.
  - A post-reset fill of `16'h0010` returns 8 clean words.
- Spurious `mem_rdata_valid` while in IDLE: no `*_data_valid` or `*_done` is asserted, and the counters are unchanged.
